// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial add sequencer. It drives one external 1-bit full adder cell and
// uses it to add two WIDTH-bit operands LSB first, one bit per clock. A carry
// flop feeds each bit's carry-out back in as the next bit's carry-in. Sum bits
// are collected in a shift register. The result registers load only when the
// job completes.
//
// Parameters
//   WIDTH     operand/result width in bits (WIDTH >= 2)
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     job request, sampled only in IDLE or DONE
//   a_in      operand A, captured on the edge that accepts start
//   b_in      operand B, captured on the edge that accepts start
//   cin_in    initial carry, captured on the edge that accepts start
//   add_a     to adder A   (current A bit in RUN, else 0)
//   add_b     to adder B   (current B bit in RUN, else 0)
//   add_cin   to adder Cin (carry flop in RUN, else 0)
//   add_sum   from adder Sum
//   add_cout  from adder Cout
//   busy      high while in RUN
//   done      high for the single DONE cycle
//   sum_out   result, updated on DONE entry only
//   cout_out  carry out of the MSB, updated on DONE entry only
//   ovf_out   signed overflow (carry into MSB ^ carry out of MSB)
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             add_a,
    output logic             add_b,
    output logic             add_cin,
    input  logic             add_sum,
    input  logic             add_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [WIDTH-1:0]   sum_sh_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   sum_out_reg;
    logic               cout_out_reg;
    logic               ovf_out_reg;

    logic               accept;
    logic               last_bit;

    // A new job may start from IDLE or straight out of DONE (back-to-back).
    assign accept   = ((state_reg == IDLE) || (state_reg == DONE)) && start;
    assign last_bit = (state_reg == RUN) && (cnt_reg == CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and adder drive
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        add_a      = 1'b0;
        add_b      = 1'b0;
        add_cin    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_sh_reg[0];
                add_b   = b_sh_reg[0];
                add_cin = carry_reg;
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            sum_sh_reg   <= '0;
            carry_reg    <= 1'b0;
            cnt_reg      <= '0;
            sum_out_reg  <= '0;
            cout_out_reg <= 1'b0;
            ovf_out_reg  <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= a_in;
            b_sh_reg  <= b_in;
            carry_reg <= cin_in;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_sh_reg <= {add_sum, sum_sh_reg[WIDTH-1:1]};
            a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
            b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
            carry_reg  <= add_cout;
            cnt_reg    <= cnt_reg + CNT_W'(1);
            if (last_bit) begin
                // The MSB sum bit is still on add_sum, so the result is
                // assembled from the adder output rather than from sum_sh_reg.
                sum_out_reg  <= {add_sum, sum_sh_reg[WIDTH-1:1]};
                cout_out_reg <= add_cout;
                // carry_reg still holds the carry into the MSB at this edge.
                ovf_out_reg  <= add_cout ^ carry_reg;
            end
        end
    end

    assign sum_out  = sum_out_reg;
    assign cout_out = cout_out_reg;
    assign ovf_out  = ovf_out_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl. It runs a WIDTH=8 instance and a
// WIDTH=2 instance. Each instance is wired to a full-adder cell that is
// modelled inline. Expected results come from plain integer addition.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    // WIDTH=8 instance signals
    logic         start = 1'b0;
    logic [W-1:0] a_in  = '0;
    logic [W-1:0] b_in  = '0;
    logic         cin_in = 1'b0;
    logic         add_a, add_b, add_cin, add_sum, add_cout;
    logic         busy, done, cout_out, ovf_out;
    logic [W-1:0] sum_out;

    // WIDTH=2 instance signals
    logic         start2 = 1'b0;
    logic [1:0]   a2 = '0;
    logic [1:0]   b2 = '0;
    logic         cin2 = 1'b0;
    logic         add_a2, add_b2, add_cin2, add_sum2, add_cout2;
    logic         busy2, done2, cout2, ovf2;
    logic [1:0]   sum2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // External full-adder cells
    assign add_sum   = add_a ^ add_b ^ add_cin;
    assign add_cout  = (add_a & add_b) | (add_a & add_cin) | (add_b & add_cin);
    assign add_sum2  = add_a2 ^ add_b2 ^ add_cin2;
    assign add_cout2 = (add_a2 & add_b2) | (add_a2 & add_cin2) | (add_b2 & add_cin2);

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy), .done(done),
        .sum_out(sum_out), .cout_out(cout_out), .ovf_out(ovf_out)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .a_in(a2), .b_in(b2), .cin_in(cin2),
        .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
        .add_sum(add_sum2), .add_cout(add_cout2),
        .busy(busy2), .done(done2),
        .sum_out(sum2), .cout_out(cout2), .ovf_out(ovf2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition, signed overflow from operand/result signs.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic c,
                                  output logic [7:0] s, output logic co, output logic ov);
        int unsigned t;
        t  = int'(a) + int'(b) + int'(c);
        s  = t[7:0];
        co = t[8];
        ov = (a[7] == b[7]) && (s[7] != a[7]);
    endfunction

    // One job on the WIDTH=8 instance. poke_at >= 0 re-pulses start (a=0x11)
    // that many cycles into RUN; the pulse must be ignored.
    task automatic do_job(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] es, input logic ec,
                          input logic eo, input int poke_at);
        int k;
        int busy_cycles;
        logic hold_ok;
        logic [7:0] prev_sum;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; cin_in = c;
        @(negedge clk);                       // accept edge has passed
        start = 1'b0;
        k = 0; busy_cycles = 0; hold_ok = 1'b1; prev_sum = sum_out;
        while (!done && k < 40) begin
            if (busy) busy_cycles++;
            if (sum_out !== prev_sum) hold_ok = 1'b0;
            if (k == poke_at) begin
                start = 1'b1; a_in = 8'h11; b_in = 8'h11;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(k), 32'(W));
        check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(W));
        check({tag, " sum_hold_in_run"}, 32'(hold_ok), 32'd1);
        check({tag, " sum"}, 32'(sum_out), 32'(es));
        check({tag, " cout"}, 32'(cout_out), 32'(ec));
        check({tag, " ovf"}, 32'(ovf_out), 32'(eo));
        $display("job %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d lat=%0d",
                 tag, a, b, c, sum_out, cout_out, ovf_out, k);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0] es;
        logic       ec, eo;
        logic [7:0] pa [3];
        logic [7:0] pb [3];
        logic [7:0] ps [3];
        logic [7:0] last_sum;
        int k, pulses, last_k, waited;
        logic stable_ok, seen_done;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        // Reset state
        rst = 1'b1;
        #1;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset sum", 32'(sum_out), 0);
        check("reset cout", 32'(cout_out), 0);
        check("reset ovf", 32'(ovf_out), 0);
        check("reset add_pins", 32'({add_a, add_b, add_cin}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            do_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, -1);
        end

        // start pulsed 3 cycles into RUN is ignored
        do_job("ignore_start", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 3);

        // Randomised jobs against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            logic rc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            model(ra, rb, rc, es, ec, eo);
            do_job($sformatf("rand%0d", i), ra, rb, rc, es, ec, eo, -1);
        end

        // Back-to-back: start held high for three jobs
        pa[0] = 8'h12; pb[0] = 8'h34;
        pa[1] = 8'hC8; pb[1] = 8'h64;
        pa[2] = 8'h7F; pb[2] = 8'h7F;
        for (int j = 0; j < 3; j++) begin
            model(pa[j], pb[j], 1'b0, ps[j], ec, eo);
        end
        @(negedge clk);
        start = 1'b1; a_in = pa[0]; b_in = pb[0]; cin_in = 1'b0;
        @(negedge clk);
        k = 0; pulses = 0; last_k = 0; stable_ok = 1'b1; last_sum = sum_out;
        while (pulses < 3 && k < 60) begin
            if (done) begin
                check($sformatf("b2b sum%0d", pulses), 32'(sum_out), 32'(ps[pulses]));
                if (pulses > 0) begin
                    check($sformatf("b2b gap%0d", pulses), 32'(k - last_k), 32'(W + 1));
                    check($sformatf("b2b stable%0d", pulses), 32'(stable_ok), 1);
                end
                $display("b2b job %0d: sum=%02h at cycle %0d", pulses, sum_out, k);
                last_k = k; last_sum = sum_out; stable_ok = 1'b1;
                pulses++;
                if (pulses < 3) begin
                    a_in = pa[pulses]; b_in = pb[pulses];
                end else begin
                    start = 1'b0;
                end
            end else if (pulses > 0 && sum_out !== last_sum) begin
                stable_ok = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("b2b pulse_count", 32'(pulses), 3);
        @(negedge clk);

        // Reset in the middle of RUN (cnt=4) aborts the job
        do_job("pre_abort", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, -1);
        @(negedge clk);
        start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);            // cnt is now 4
        rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        check("abort sum", 32'(sum_out), 0);
        check("abort cout_ovf", 32'({cout_out, ovf_out}), 0);
        check("abort add_pins", 32'({add_a, add_b, add_cin}), 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort no_done", 32'(seen_done), 0);
        $display("abort: reset at cnt=4, outputs cleared");
        do_job("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, -1);

        // WIDTH=2 instance: 3 + 3 + 1
        @(negedge clk);
        start2 = 1'b1; a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        waited = 0;
        while (!done2 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("w2 latency", 32'(waited), 2);
        check("w2 sum", 32'(sum2), 3);
        check("w2 cout", 32'(cout2), 1);
        check("w2 ovf", 32'(ovf2), 0);
        $display("w2 job: a=3 b=3 cin=1 -> sum=%0d cout=%0d ovf=%0d lat=%0d",
                 sum2, cout2, ovf2, waited);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
